// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM state encoding (common with the APB slave)
// and the response record layout {rdata, err, timeout}.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SETUP  = 2'b01,
        ACCESS = 2'b10
    } apb_state_e;

    // Low bits of a response record; read data sits above these flags.
    typedef struct packed {
        logic err;
        logic timeout;
    } rsp_flags_t;

    localparam int RSP_FLAGS_W    = $bits(rsp_flags_t);
    localparam int RSP_FIFO_DEPTH = 2;

    // Watchdog counter width; a disabled watchdog still gets a 1-bit counter.
    function automatic int wd_width(input int timeout);
        return (timeout < 2) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/apb_rsp_fifo.sv
// Small synchronous FIFO for APB responses. Push and pop may coincide;
// a push into a full FIFO is only taken when the head is popped that cycle.
module apb_rsp_fifo
    import apb_pkg::*;
#(
    parameter int  WIDTH = 34,
    parameter int  DEPTH = RSP_FIFO_DEPTH,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_empty,
    output logic             o_full,
    output logic [CNT_W-1:0] o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_empty;
    logic w_full;
    logic w_do_push;
    logic w_do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == CNT_W'(DEPTH));
    assign w_do_pop  = i_pop && !w_empty;
    assign w_do_push = i_push && (!w_full || w_do_pop);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= ptr_inc(r_wr_ptr);
            end
            if (w_do_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_empty = w_empty;
    assign o_full  = w_full;
    assign o_count = r_count;

endmodule

// File: rtl/apb_master.sv
// APB3 requester: valid/ready commands in, registered APB transfers out,
// one buffered response per command, watchdog abort for stuck slaves.
module apb_master
    import apb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR       = 5,
    parameter int TIMEOUT    = 16
) (
    input  logic                  pclk,
    input  logic                  preset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR-1:0]       cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [ADDR-1:0]       paddr,
    output logic [DATA_WIDTH-1:0] pwdata,
    input  logic [DATA_WIDTH-1:0] prdata,
    input  logic                  pready,
    input  logic                  pslverr
);

    localparam int              WD_W     = wd_width(TIMEOUT);
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT);
    localparam bit              WD_EN    = (TIMEOUT != 0);
    localparam int              RSP_W    = DATA_WIDTH + RSP_FLAGS_W;
    localparam int              CNT_W    = $clog2(RSP_FIFO_DEPTH + 1);

    apb_state_e            r_state;
    logic                  r_psel;
    logic                  r_penable;
    logic                  r_pwrite;
    logic [ADDR-1:0]       r_paddr;
    logic [DATA_WIDTH-1:0] r_pwdata;
    logic [WD_W-1:0]       r_wd_cnt;

    logic                  w_complete;
    logic                  w_abort;
    logic                  w_cmd_ready;
    logic                  w_accept;
    logic                  w_push;
    logic                  w_pop;
    logic [CNT_W-1:0]      w_count;
    logic [CNT_W-1:0]      w_free;
    logic                  w_empty;
    logic                  w_full;
    logic [RSP_W-1:0]      w_push_data;
    logic [RSP_W-1:0]      w_head;
    logic [DATA_WIDTH-1:0] w_push_rdata;
    rsp_flags_t            w_push_flags;
    logic [DATA_WIDTH-1:0] w_head_rdata;
    rsp_flags_t            w_head_flags;

    // Free slots exclude a same-cycle pop so the accept path never depends on rsp_ready.
    assign w_free      = CNT_W'(RSP_FIFO_DEPTH) - w_count;
    assign w_complete  = (r_state == ACCESS) && pready;
    assign w_abort     = WD_EN && (r_state == ACCESS) && !pready && (r_wd_cnt == WD_LIMIT);
    assign w_cmd_ready = ((r_state == IDLE) && (w_free >= CNT_W'(1)))
                      || (w_complete && (w_free >= CNT_W'(2)));
    assign w_accept    = cmd_valid && w_cmd_ready;

    assign w_push               = w_complete || w_abort;
    assign w_push_rdata         = (w_abort || r_pwrite) ? '0 : prdata;
    assign w_push_flags.err     = w_abort ? 1'b1 : pslverr;
    assign w_push_flags.timeout = w_abort;
    assign w_push_data          = {w_push_rdata, w_push_flags};

    always_ff @(posedge pclk) begin
        if (preset) begin
            r_state   <= IDLE;
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_pwrite  <= 1'b0;
            r_paddr   <= '0;
            r_pwdata  <= '0;
            r_wd_cnt  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_state   <= SETUP;
                        r_psel    <= 1'b1;
                        r_penable <= 1'b0;
                        r_pwrite  <= cmd_write;
                        r_paddr   <= cmd_addr;
                        r_pwdata  <= cmd_wdata;
                    end
                end
                SETUP: begin
                    r_state   <= ACCESS;
                    r_penable <= 1'b1;
                    r_wd_cnt  <= '0;
                end
                ACCESS: begin
                    if (w_complete && w_accept) begin
                        r_state   <= SETUP;
                        r_psel    <= 1'b1;
                        r_penable <= 1'b0;
                        r_pwrite  <= cmd_write;
                        r_paddr   <= cmd_addr;
                        r_pwdata  <= cmd_wdata;
                    end else if (w_complete || w_abort) begin
                        r_state   <= IDLE;
                        r_psel    <= 1'b0;
                        r_penable <= 1'b0;
                    end else if (WD_EN) begin
                        r_wd_cnt <= r_wd_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_psel    <= 1'b0;
                    r_penable <= 1'b0;
                end
            endcase
        end
    end

    apb_rsp_fifo #(
        .WIDTH (RSP_W),
        .DEPTH (RSP_FIFO_DEPTH)
    ) u_rsp_fifo (
        .i_clk       (pclk),
        .i_rst       (preset),
        .i_push      (w_push),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_empty     (w_empty),
        .o_full      (w_full),
        .o_count     (w_count)
    );

    assign w_pop = rsp_ready && !w_empty;
    assign {w_head_rdata, w_head_flags} = w_head;

    // Outputs read as zero whenever the buffer is empty, not stale entries.
    assign rsp_valid   = !w_empty;
    assign rsp_rdata   = w_empty ? '0 : w_head_rdata;
    assign rsp_err     = !w_empty && w_head_flags.err;
    assign rsp_timeout = !w_empty && w_head_flags.timeout;

    assign cmd_ready = w_cmd_ready;
    assign psel      = r_psel;
    assign penable   = r_penable;
    assign pwrite    = r_pwrite;
    assign paddr     = r_paddr;
    assign pwdata    = r_pwdata;

    // Full flag is implied by w_free; kept on the FIFO port for other users.
    logic w_unused;
    assign w_unused = w_full;

endmodule
